// File: rtl/sdram_bist_if.sv
// rtl/sdram_bist_if.sv - SDRAM controller command/read-data port shared by the BIST and the controller
interface sdram_bist_if #(
    parameter int ADDR_W = 23,
    parameter int DATA_W = 32
) ();
    logic              cmd_ready;
    logic              cmd_enable;
    logic              cmd_wr;
    logic [ADDR_W-1:0] cmd_address;
    logic [DATA_W-1:0] cmd_data_in;
    logic [DATA_W-1:0] data_out;
    logic              data_out_ready;

    modport master (
        input  cmd_ready, data_out, data_out_ready,
        output cmd_enable, cmd_wr, cmd_address, cmd_data_in
    );

    modport slave (
        output cmd_ready, data_out, data_out_ready,
        input  cmd_enable, cmd_wr, cmd_address, cmd_data_in
    );
endinterface

// File: rtl/sdram_bist.sv
// rtl/sdram_bist.sv - SDRAM write-then-verify self-test engine; SDRAM_BIST_UART_EN adds a UART result frame
module sdram_bist #(
    parameter int                ADDR_W    = 23,
    parameter int                DATA_W    = 32,
    parameter logic [ADDR_W-1:0] LAST_ADDR = '1,
    parameter int                TIMEOUT   = 1024
) (
    input  logic              clk,
    input  logic              rst,
    sdram_bist_if.master      bus,
    input  logic              i_start,
    input  logic [1:0]        i_mode,
    input  logic              i_stop_on_err,
    output logic              o_busy,
    output logic              o_done,
    output logic              o_pass,
    output logic              o_timeout,
    output logic [15:0]       o_err_count,
    output logic [ADDR_W-1:0] o_fail_addr,
    output logic [DATA_W-1:0] o_fail_exp,
    output logic [DATA_W-1:0] o_fail_act
`ifdef SDRAM_BIST_UART_EN
    ,
    output logic [7:0]        o_tx_byte,
    output logic              o_tx_en,
    input  logic              i_tx_ready
`endif
);
    localparam int TW = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {
        S_IDLE, S_WR_ISSUE, S_WR_NEXT, S_RD_ISSUE, S_RD_WAIT, S_FINISH, S_TX_GAP, S_DONE
    } state_t;

    state_t            r_state, w_next;
    logic [ADDR_W-1:0] r_addr;
    logic [1:0]        r_mode;
    logic              r_stop;
    logic [TW-1:0]     r_timer;
    logic [15:0]       r_err_count;
    logic [ADDR_W-1:0] r_fail_addr;
    logic [DATA_W-1:0] r_fail_exp, r_fail_act;
    logic              r_timeout, r_pass;
    logic              w_cmd_enable, w_cmd_wr;

    // Pattern depends only on the pass-relative address, so the read pass regenerates it exactly.
    function automatic logic [DATA_W-1:0] pattern(input logic [1:0] m, input logic [ADDR_W-1:0] a);
        logic [DATA_W-1:0] z;
        z = DATA_W'(a);
        case (m)
            2'd0:    return z + DATA_W'(1);
            2'd1:    return z;
            2'd2:    return DATA_W'(1) << (32'(a) % DATA_W);
            default: return ~z;
        endcase
    endfunction

    logic [DATA_W-1:0] w_exp;
    logic w_is_last, w_rd_end, w_rd_err, w_to, w_err, w_start, w_pass_now, w_rd_stop;

    assign w_exp      = pattern(r_mode, r_addr);
    assign w_is_last  = (r_addr == LAST_ADDR);
    assign w_to       = (r_state == S_RD_WAIT) && !bus.data_out_ready && (r_timer == TW'(TIMEOUT - 1));
    assign w_rd_err   = (r_state == S_RD_WAIT) && bus.data_out_ready && (bus.data_out != w_exp);
    assign w_rd_end   = (r_state == S_RD_WAIT) && (bus.data_out_ready || w_to);
    assign w_err      = w_rd_err || w_to;
    assign w_rd_stop  = (w_err && r_stop) || w_is_last;
    assign w_start    = i_start && (r_state == S_IDLE || r_state == S_DONE);
    assign w_pass_now = (r_err_count == 16'd0) && !r_timeout;

`ifdef SDRAM_BIST_UART_EN
    localparam int NB   = (ADDR_W + 7) / 8;
    localparam int NFR  = 4 + NB;
    localparam int AP_W = NB * 8;

    logic [7:0]      r_byte;
    logic [7:0]      w_frame_byte;
    logic [AP_W-1:0] w_addr_pad, w_addr_sh;
    logic            w_last_byte;

    assign w_addr_pad  = AP_W'(r_fail_addr);
    assign w_addr_sh   = w_addr_pad >> (8 * (NFR - 1 - int'(r_byte)));
    assign w_last_byte = (r_byte == 8'(NFR - 1));

    always_comb begin
        w_frame_byte = w_addr_sh[7:0];
        case (r_byte)
            8'd0:    w_frame_byte = 8'hAA;
            8'd1:    w_frame_byte = {w_pass_now, r_timeout, 6'b0};
            8'd2:    w_frame_byte = r_err_count[15:8];
            8'd3:    w_frame_byte = r_err_count[7:0];
            default: w_frame_byte = w_addr_sh[7:0];
        endcase
    end

    assign o_tx_en   = (r_state == S_FINISH) && i_tx_ready;
    assign o_tx_byte = o_tx_en ? w_frame_byte : 8'd0;
`endif

    always_ff @(posedge clk) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next       = r_state;
        w_cmd_enable = 1'b0;
        w_cmd_wr     = 1'b0;
        case (r_state)
            S_IDLE, S_DONE: if (i_start) w_next = S_WR_ISSUE;
            S_WR_ISSUE: begin
                w_cmd_enable = 1'b1;
                w_cmd_wr     = 1'b1;
                if (bus.cmd_ready) w_next = S_WR_NEXT;
            end
            S_WR_NEXT:  w_next = w_is_last ? S_RD_ISSUE : S_WR_ISSUE;
            S_RD_ISSUE: begin
                w_cmd_enable = 1'b1;
                if (bus.cmd_ready) w_next = S_RD_WAIT;
            end
            S_RD_WAIT:  if (w_rd_end) w_next = w_rd_stop ? S_FINISH : S_RD_ISSUE;
`ifdef SDRAM_BIST_UART_EN
            S_FINISH:   if (i_tx_ready) w_next = S_TX_GAP;
            S_TX_GAP:   w_next = w_last_byte ? S_DONE : S_FINISH;
`else
            S_FINISH:   w_next = S_DONE;
            S_TX_GAP:   w_next = S_DONE;
`endif
            default:    w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_addr      <= '0;
            r_mode      <= 2'd0;
            r_stop      <= 1'b0;
            r_timer     <= '0;
            r_err_count <= 16'd0;
            r_fail_addr <= '0;
            r_fail_exp  <= '0;
            r_fail_act  <= '0;
            r_timeout   <= 1'b0;
            r_pass      <= 1'b0;
        end else begin
            if (w_start) begin
                r_addr      <= '0;
                r_mode      <= i_mode;
                r_stop      <= i_stop_on_err;
                r_err_count <= 16'd0;
                r_fail_addr <= '0;
                r_fail_exp  <= '0;
                r_fail_act  <= '0;
                r_timeout   <= 1'b0;
                r_pass      <= 1'b0;
            end
            if (r_state == S_WR_NEXT)
                r_addr <= w_is_last ? '0 : r_addr + ADDR_W'(1);
            if (r_state == S_RD_ISSUE && bus.cmd_ready)
                r_timer <= '0;
            if (r_state == S_RD_WAIT) begin
                r_timer <= r_timer + TW'(1);
                if (w_rd_end && !w_rd_stop) r_addr <= r_addr + ADDR_W'(1);
            end
            // Only the first error of a run is captured; the count keeps going and saturates.
            if (w_err) begin
                if (r_err_count != 16'hFFFF) r_err_count <= r_err_count + 16'd1;
                if (r_err_count == 16'd0) begin
                    r_fail_addr <= r_addr;
                    r_fail_exp  <= w_exp;
                    r_fail_act  <= w_to ? '0 : bus.data_out;
                end
                if (w_to) r_timeout <= 1'b1;
            end
            if (r_state != S_DONE && w_next == S_DONE)
                r_pass <= w_pass_now;
        end
    end

`ifdef SDRAM_BIST_UART_EN
    always_ff @(posedge clk) begin
        if (rst || w_start)          r_byte <= 8'd0;
        else if (r_state == S_TX_GAP) r_byte <= r_byte + 8'd1;
    end
`endif

    assign bus.cmd_enable  = w_cmd_enable;
    assign bus.cmd_wr      = w_cmd_wr;
    assign bus.cmd_address = r_addr;
    assign bus.cmd_data_in = w_cmd_wr ? w_exp : '0;

    assign o_busy      = (r_state != S_IDLE) && (r_state != S_DONE);
    assign o_done      = (r_state == S_DONE);
    assign o_pass      = r_pass;
    assign o_timeout   = r_timeout;
    assign o_err_count = r_err_count;
    assign o_fail_addr = r_fail_addr;
    assign o_fail_exp  = r_fail_exp;
    assign o_fail_act  = r_fail_act;
endmodule

// File: tb/tb_sdram_bist.sv
// tb/tb_sdram_bist.sv - randomized self-checking bench for sdram_bist against a pass/fail reference model
module tb_sdram_bist;
    localparam int AW = 4, DW = 32, TO = 8, NADDR = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic          start = 1'b0;
    logic [1:0]    mode = 2'd0;
    logic          stop = 1'b0;
    logic          busy, done, pass, tmo;
    logic [15:0]   err_count;
    logic [AW-1:0] fail_addr;
    logic [DW-1:0] fail_exp, fail_act;

    sdram_bist_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

`ifdef SDRAM_BIST_UART_EN
    logic [7:0] tx_byte;
    logic       tx_en;
    logic       tx_ready = 1'b0;
    logic [7:0] frame[$];
    always @(posedge clk) begin
        #1;
        tx_ready = ($urandom_range(0, 2) != 0);
    end
`endif

    sdram_bist #(.ADDR_W(AW), .DATA_W(DW), .LAST_ADDR(4'hF), .TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst), .bus(bus),
        .i_start(start), .i_mode(mode), .i_stop_on_err(stop),
        .o_busy(busy), .o_done(done), .o_pass(pass), .o_timeout(tmo),
        .o_err_count(err_count), .o_fail_addr(fail_addr),
        .o_fail_exp(fail_exp), .o_fail_act(fail_act)
`ifdef SDRAM_BIST_UART_EN
        , .o_tx_byte(tx_byte), .o_tx_en(tx_en), .i_tx_ready(tx_ready)
`endif
    );

    int n_cmp = 0, n_bad = 0;

    task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", tag, act, exp);
        end
    endtask

    function automatic logic [31:0] pat(input int m, input int a);
        case (m)
            0:       return 32'(a + 1);
            1:       return 32'(a);
            2:       return 32'h1 << (a % 32);
            default: return ~32'(a);
        endcase
    endfunction

    logic [31:0]   mem[NADDR];
    int            n_wr, n_rd, viol;
    int            corrupt_addr = -1, drop_addr = -1;
    bit            rand_ready = 1'b0;
    bit            rd_pend = 1'b0;
    int            rd_delay, rd_addr;
    bit            prev_en = 1'b0, prev_acc = 1'b0, prev_wr;
    logic [AW-1:0] prev_a;
    logic [DW-1:0] prev_d;

    initial begin
        bus.cmd_ready      = 1'b0;
        bus.data_out       = '0;
        bus.data_out_ready = 1'b0;
    end

    // Memory model and protocol monitor; cmd_ready/data_out_ready change only here, so the
    // values seen at this falling edge are exactly what the next rising edge samples.
    always @(negedge clk) begin
        bit acc;
        bus.data_out_ready = 1'b0;
        if (rst) begin
            rd_pend  = 1'b0;
            prev_en  = 1'b0;
            prev_acc = 1'b0;
        end else begin
            if (rd_pend) begin
                if (rd_delay > 1) rd_delay--;
                else begin
                    rd_pend = 1'b0;
                    if (rd_addr != drop_addr) begin
                        bus.data_out       = mem[rd_addr] ^ ((rd_addr == corrupt_addr) ? 32'h1 : 32'h0);
                        bus.data_out_ready = 1'b1;
                    end
                end
            end
            bus.cmd_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
            if (prev_en && !prev_acc &&
                !(bus.cmd_enable && bus.cmd_wr == prev_wr && bus.cmd_address == prev_a && bus.cmd_data_in == prev_d))
                viol++;
            acc = bus.cmd_enable && bus.cmd_ready;
            if (acc && prev_acc) viol++;
            if (acc) begin
                if (bus.cmd_wr) begin
                    check_eq("wr_addr", bus.cmd_address, n_wr % NADDR);
                    check_eq("wr_data", bus.cmd_data_in, pat(mode, bus.cmd_address));
                    mem[bus.cmd_address] = bus.cmd_data_in;
                    n_wr++;
                end else begin
                    check_eq("rd_addr", bus.cmd_address, n_rd);
                    n_rd++;
                    rd_pend  = 1'b1;
                    rd_delay = $urandom_range(1, 3);
                    rd_addr  = bus.cmd_address;
                end
            end
            prev_acc = acc;
            prev_en  = bus.cmd_enable;
            prev_wr  = bus.cmd_wr;
            prev_a   = bus.cmd_address;
            prev_d   = bus.cmd_data_in;
`ifdef SDRAM_BIST_UART_EN
            if (tx_en) frame.push_back(tx_byte);
`endif
        end
    end

    task automatic check_idle_outputs(input string tag);
        check_eq({tag, ".cmd_enable"}, bus.cmd_enable, 0);
        check_eq({tag, ".cmd_wr"}, bus.cmd_wr, 0);
        check_eq({tag, ".cmd_address"}, bus.cmd_address, 0);
        check_eq({tag, ".cmd_data_in"}, bus.cmd_data_in, 0);
        check_eq({tag, ".busy_done_pass_to"}, {busy, done, pass, tmo}, 0);
        check_eq({tag, ".err_count"}, err_count, 0);
        check_eq({tag, ".fail_all"}, {fail_addr, fail_exp, fail_act}, 0);
    endtask

    task automatic launch(input int m, input bit s, input int ca, input int da, input bit rr);
        mode = 2'(m); stop = s; corrupt_addr = ca; drop_addr = da; rand_ready = rr;
        n_wr = 0; n_rd = 0; viol = 0;
`ifdef SDRAM_BIST_UART_EN
        frame.delete();
`endif
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
    endtask

    task automatic run_test(input string tag, input int m, input bit s, input int ca, input int da,
                            input bit rr, input bit poke);
        int cyc, e_err, e_nrd, e_faddr;
        bit e_to, bad;
        logic [31:0] e_fexp, e_fact, ex, ac;
        launch(m, s, ca, da, rr);
        cyc = 0;
        while (!done && cyc < 5000) begin
            start = poke && (cyc == 20);
            @(posedge clk); #1;
            cyc++;
        end
        start = 1'b0;
        check_eq({tag, ".finished"}, done, 1);

        e_err = 0; e_to = 0; e_nrd = 0; e_faddr = 0; e_fexp = 0; e_fact = 0;
        for (int a = 0; a < NADDR; a++) begin
            e_nrd = a + 1;
            ex = pat(m, a);
            bad = 1'b0;
            ac = ex;
            if (a == da) begin bad = 1'b1; ac = 32'h0; e_to = 1'b1; end
            else if (a == ca) begin bad = 1'b1; ac = ex ^ 32'h1; end
            if (bad) begin
                if (e_err == 0) begin e_faddr = a; e_fexp = ex; e_fact = ac; end
                e_err++;
                if (s) break;
            end
        end
        check_eq({tag, ".busy"}, busy, 0);
        check_eq({tag, ".pass"}, pass, (e_err == 0 && !e_to));
        check_eq({tag, ".timeout"}, tmo, e_to);
        check_eq({tag, ".err_count"}, err_count, e_err);
        check_eq({tag, ".fail_addr"}, fail_addr, e_faddr);
        check_eq({tag, ".fail_exp"}, fail_exp, e_fexp);
        check_eq({tag, ".fail_act"}, fail_act, e_fact);
        check_eq({tag, ".n_writes"}, n_wr, NADDR);
        check_eq({tag, ".n_reads"}, n_rd, e_nrd);
        check_eq({tag, ".protocol"}, viol, 0);
`ifdef SDRAM_BIST_UART_EN
        begin
            logic [7:0] fx[5];
            fx[0] = 8'hAA;
            fx[1] = {(e_err == 0 && !e_to), e_to, 6'b0};
            fx[2] = 8'(e_err >> 8);
            fx[3] = 8'(e_err);
            fx[4] = 8'(e_faddr);
            check_eq({tag, ".frame_len"}, frame.size(), 5);
            for (int i = 0; i < 5 && i < frame.size(); i++)
                check_eq($sformatf("%s.frame[%0d]", tag, i), frame[i], fx[i]);
        end
`endif
    endtask

    initial begin
        int cyc;
        repeat (3) @(posedge clk);
        #1 check_idle_outputs("reset");
        rst = 1'b0;

        run_test("clean_m1", 1, 1'b0, -1, -1, 1'b0, 1'b0);
        run_test("corrupt5", 1, 1'b0, 5, -1, 1'b0, 1'b0);
        run_test("corrupt5_stop", 1, 1'b1, 5, -1, 1'b0, 1'b0);
        run_test("drop3", 1, 1'b0, -1, 3, 1'b0, 1'b0);

        // Reset in the middle of the read pass, then a clean rerun.
        launch(2, 1'b0, -1, -1, 1'b1);
        cyc = 0;
        while (n_rd < 5 && cyc < 2000) begin @(posedge clk); #1; cyc++; end
        check_eq("midrst.reached_reads", (n_rd >= 5), 1);
        rst = 1'b1;
        @(posedge clk); #1;
        check_idle_outputs("midrst");
        @(posedge clk); #1 rst = 1'b0;
        run_test("after_rst", 2, 1'b0, -1, -1, 1'b1, 1'b0);

        for (int t = 0; t < 8; t++) begin
            int m, ca, da;
            bit s;
            m  = $urandom_range(0, 3);
            s  = 1'($urandom_range(0, 1));
            ca = $urandom_range(0, 23);
            da = $urandom_range(0, 23);
            if (ca >= NADDR) ca = -1;
            if (da >= NADDR || da == ca) da = -1;
            run_test($sformatf("rand%0d", t), m, s, ca, da, 1'b1, 1'b1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
